// File: rtl/matvec_mac_if.sv
// matvec_mac_if: request/result handshake and weight-RAM bus of matvec_mac.
// Ports: start, inVector, ack (requester to engine); result, valid, busy (engine to requester);
// weightAddr (engine to RAM); weightRow (RAM to engine).
interface matvec_mac_if #(
    parameter int NROW          = 16,
    parameter int NCOL          = 16,
    parameter int BITWIDTH      = 18,
    parameter int ADDR_BITWIDTH = $clog2(NCOL)
);
    logic                         start;
    logic [BITWIDTH*NCOL-1:0]     inVector;
    logic [ADDR_BITWIDTH-1:0]     weightAddr;
    logic [BITWIDTH*NROW-1:0]     weightRow;
    logic [BITWIDTH*NROW-1:0]     result;
    logic                         valid;
    logic                         ack;
    logic                         busy;

    modport master (
        output start, inVector, weightRow, ack,
        input  weightAddr, result, valid, busy
    );

    modport slave (
        input  start, inVector, weightRow, ack,
        output weightAddr, result, valid, busy
    );
endinterface

// File: rtl/matvec_mac.sv
// matvec_mac: column-serial matrix-vector MAC with saturated output under valid/ack.
// Ports: clk; reset (sync, active-low); bus (slave): start/inVector request, weightAddr/weightRow
// weight-RAM column port, result/valid/ack output handshake, busy while RUN or DONE.
module matvec_mac #(
    parameter int NROW     = 16,
    parameter int NCOL     = 16,
    parameter int BITWIDTH = 18,
    parameter int FRAC     = 11
) (
    input logic         clk,
    input logic         reset,
    matvec_mac_if.slave bus
);
    localparam int ADDR_BITWIDTH = $clog2(NCOL);
    localparam int ACC_WIDTH     = 2*BITWIDTH + ADDR_BITWIDTH;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [ADDR_BITWIDTH-1:0] LAST = ADDR_BITWIDTH'(NCOL-1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = {{(ACC_WIDTH-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ~SAT_HI;

    logic [1:0]                   state;
    logic [ADDR_BITWIDTH-1:0]     col_cnt;
    logic [ADDR_BITWIDTH-1:0]     weight_addr;
    logic [BITWIDTH*NROW-1:0]     result;
    logic [BITWIDTH*NROW-1:0]     result_n;
    logic                         valid;
    logic signed [BITWIDTH-1:0]   x   [NCOL];
    logic signed [BITWIDTH-1:0]   w   [NROW];
    logic signed [ACC_WIDTH-1:0]  acc [NROW];
    logic signed [ACC_WIDTH-1:0]  sh  [NROW];

    assign bus.weightAddr = weight_addr;
    assign bus.result     = result;
    assign bus.valid      = valid;
    assign bus.busy       = state != IDLE;

    // Arithmetic shift floors toward -inf; clamping happens only here, never in the accumulators.
    always_comb begin
        result_n = '0;
        for (int i = 0; i < NROW; i++) begin
            w[i] = bus.weightRow[i*BITWIDTH +: BITWIDTH];
            sh[i] = acc[i] >>> FRAC;
            result_n[i*BITWIDTH +: BITWIDTH] = sh[i] > SAT_HI ? SAT_HI[BITWIDTH-1:0] :
                                              sh[i] < SAT_LO ? SAT_LO[BITWIDTH-1:0] :
                                              sh[i][BITWIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            col_cnt     <= '0;
            weight_addr <= '0;
            result      <= '0;
            valid       <= 1'b0;
            for (int i = 0; i < NROW; i++) acc[i] <= '0;
            for (int j = 0; j < NCOL; j++) x[j] <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    for (int j = 0; j < NCOL; j++) x[j] <= bus.inVector[j*BITWIDTH +: BITWIDTH];
                    for (int i = 0; i < NROW; i++) acc[i] <= '0;
                    col_cnt     <= '0;
                    weight_addr <= '0;
                    state       <= RUN;
                end
                RUN: begin
                    // Operands are sign-extended first so the product is exact at ACC_WIDTH.
                    for (int i = 0; i < NROW; i++)
                        acc[i] <= acc[i] + ACC_WIDTH'(w[i]) * ACC_WIDTH'(x[col_cnt]);
                    col_cnt <= col_cnt + 1'b1;
                    if (col_cnt == LAST) state <= DONE;
                    else weight_addr <= col_cnt + 1'b1;
                end
                DONE: if (!valid) begin
                    result <= result_n;
                    valid  <= 1'b1;
                end else if (bus.ack) begin
                    valid       <= 1'b0;
                    weight_addr <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matvec_mac.sv
// tb_matvec_mac: directed bench for matvec_mac with a falling-edge weight RAM (weight[i][j] = j.0).
module tb_matvec_mac;
    localparam int NROW = 16;
    localparam int NCOL = 16;
    localparam int BW   = 18;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc;

    matvec_mac_if #(.NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW)) bus ();

    matvec_mac #(.NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW), .FRAC(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        for (int i = 0; i < NROW; i++) bus.weightRow[i*BW +: BW] <= BW'(int'(bus.weightAddr) << 11);

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW*NCOL-1:0] vec_one(input int j, input int v);
        logic [BW*NCOL-1:0] r = '0;
        r[j*BW +: BW] = BW'(v);
        return r;
    endfunction

    function automatic logic [BW*NCOL-1:0] vec_all(input int v);
        logic [BW*NCOL-1:0] r;
        for (int j = 0; j < NCOL; j++) r[j*BW +: BW] = BW'(v);
        return r;
    endfunction

    task automatic run(input logic [BW*NCOL-1:0] v, output int n);
        bus.inVector = v;
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        n = 0;
        while (!bus.valid && n < 40) begin
            step;
            n++;
        end
    endtask

    task automatic do_ack;
        bus.ack = 1'b1;
        step;
        bus.ack = 1'b0;
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.ack = 1'b0;
        bus.inVector = '0;
        reset = 1'b0;
        repeat (2) step;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.weightAddr !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", bus.weightAddr); end
        checks++; if (bus.result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
        reset = 1'b1;
        step;
    endtask

    task automatic test_basic;
        bus.inVector = vec_one(3, 1024);
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.weightAddr !== 4'd0) begin errors++; $display("FAIL basic_t0 got busy %b addr %0d want busy 1 addr 0", bus.busy, bus.weightAddr); end
        for (int k = 1; k <= 16; k++) begin
            step;
            checks++; if (bus.valid !== 1'b0 || int'(bus.weightAddr) != (k > 15 ? 15 : k)) begin errors++; $display("FAIL basic_seq cycle %0d got valid %b addr %0d want valid 0 addr %0d", k, bus.valid, bus.weightAddr, k > 15 ? 15 : k); end
        end
        step;
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL basic_latency got valid %b want 1 at cycle 17", bus.valid); end
        for (int i = 0; i < NROW; i++) begin
            checks++; if (bus.result[i*BW +: BW] !== BW'(3072)) begin errors++; $display("FAIL basic_row %0d got %0d want 3072", i, $signed(bus.result[i*BW +: BW])); end
        end
        do_ack;
        checks++; if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.weightAddr !== 4'd0) begin errors++; $display("FAIL basic_ack got valid %b busy %b addr %0d want 0 0 0", bus.valid, bus.busy, bus.weightAddr); end
        checks++; if (bus.result !== {NROW{BW'(3072)}}) begin errors++; $display("FAIL basic_keep got %h want all 3072", bus.result); end
    endtask

    task automatic test_saturate;
        run(vec_all(2048), cyc);
        checks++; if (cyc !== 17) begin errors++; $display("FAIL sat_pos_latency got %0d want 17", cyc); end
        for (int i = 0; i < NROW; i++) begin
            checks++; if (bus.result[i*BW +: BW] !== BW'(131071)) begin errors++; $display("FAIL sat_pos row %0d got %0d want 131071", i, $signed(bus.result[i*BW +: BW])); end
        end
        do_ack;
        run(vec_all(-2048), cyc);
        checks++; if (cyc !== 17) begin errors++; $display("FAIL sat_neg_latency got %0d want 17", cyc); end
        for (int i = 0; i < NROW; i++) begin
            checks++; if (bus.result[i*BW +: BW] !== BW'(-131072)) begin errors++; $display("FAIL sat_neg row %0d got %0d want -131072", i, $signed(bus.result[i*BW +: BW])); end
        end
        do_ack;
    endtask

    task automatic test_start_ignored;
        bus.inVector = vec_one(3, 1024);
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        repeat (5) step;
        bus.inVector = vec_all(2048);
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        cyc = 6;
        while (!bus.valid && cyc < 40) begin
            step;
            cyc++;
        end
        checks++; if (cyc !== 17) begin errors++; $display("FAIL ign_latency got %0d want 17", cyc); end
        bus.start = 1'b1;
        repeat (2) step;
        bus.start = 1'b0;
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL ign_done_valid got %b want 1", bus.valid); end
        checks++; if (bus.result !== {NROW{BW'(3072)}}) begin errors++; $display("FAIL ign_result got %h want all 3072", bus.result); end
        do_ack;
        step;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_idle got busy %b want 0", bus.busy); end
    endtask

    task automatic test_handshake;
        logic [BW*NROW-1:0] want = {NROW{BW'(-1)}};
        run(vec_one(1, -1), cyc);
        checks++; if (cyc !== 17) begin errors++; $display("FAIL hs_latency got %0d want 17", cyc); end
        for (int i = 0; i < NROW; i++) begin
            checks++; if (bus.result[i*BW +: BW] !== BW'(-1)) begin errors++; $display("FAIL floor row %0d got %0d want -1", i, $signed(bus.result[i*BW +: BW])); end
        end
        for (int k = 0; k < 5; k++) begin
            step;
            checks++; if (bus.valid !== 1'b1 || bus.result !== want) begin errors++; $display("FAIL hs_hold cycle %0d got valid %b result %h want valid 1 result %h", k, bus.valid, bus.result, want); end
        end
        bus.inVector = vec_all(2048);
        bus.ack = 1'b1;
        bus.start = 1'b1;
        step;
        bus.ack = 1'b0;
        bus.start = 1'b0;
        checks++; if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL hs_ack_start got valid %b busy %b want 0 0", bus.valid, bus.busy); end
        step;
        checks++; if (bus.busy !== 1'b0 || bus.weightAddr !== 4'd0) begin errors++; $display("FAIL hs_no_run got busy %b addr %0d want 0 0", bus.busy, bus.weightAddr); end
    endtask

    task automatic test_ack_held;
        bus.ack = 1'b1;
        run(vec_one(5, 2048), cyc);
        checks++; if (cyc !== 17) begin errors++; $display("FAIL ackh_latency got %0d want 17", cyc); end
        checks++; if (bus.result !== {NROW{BW'(10240)}}) begin errors++; $display("FAIL ackh_result got %h want all 10240", bus.result); end
        step;
        bus.ack = 1'b0;
        checks++; if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL ackh_one_cycle got valid %b busy %b want 0 0", bus.valid, bus.busy); end
    endtask

    task automatic test_reset_mid_run;
        bus.inVector = vec_all(2048);
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        repeat (8) step;
        checks++; if (bus.weightAddr !== 4'd8) begin errors++; $display("FAIL rst_pre_addr got %0d want 8", bus.weightAddr); end
        reset = 1'b0;
        step;
        checks++; if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.weightAddr !== 4'd0) begin errors++; $display("FAIL rst_mid got valid %b busy %b addr %0d want 0 0 0", bus.valid, bus.busy, bus.weightAddr); end
        checks++; if (bus.result !== '0) begin errors++; $display("FAIL rst_mid_result got %h want 0", bus.result); end
        reset = 1'b1;
        step;
    endtask

    task automatic test_after_reset;
        run(vec_one(3, 1024), cyc);
        checks++; if (cyc !== 17) begin errors++; $display("FAIL fresh_latency got %0d want 17", cyc); end
        for (int i = 0; i < NROW; i++) begin
            checks++; if (bus.result[i*BW +: BW] !== BW'(3072)) begin errors++; $display("FAIL fresh_row %0d got %0d want 3072", i, $signed(bus.result[i*BW +: BW])); end
        end
        do_ack;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_saturate;
        test_start_ignored;
        test_handshake;
        test_ack_held;
        test_reset_mid_run;
        test_after_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
